// File: rtl/jump_target_buffer.sv
// Direct-mapped jump target buffer: caches J/JAL instruction-index fields by PC so that fetch
// can redirect a cycle early. Optional hit/miss statistics are enabled by defining JTB_STATS_EN.
module jump_target_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic        upd_err,
  input  logic        flush_req,
  output logic        busy
`ifdef JTB_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;

  logic                 state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [DEPTH];
  logic [25:0]          imm_q [DEPTH];
  logic                 upd_err_q, upd_err_d;

  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic [31:0]          lk_pc4, up_pc4;
  logic                 upd_legal, upd_accept, upd_write;

  // Lookup path
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign lk_pc4 = lookup_pc + 32'd4;

  assign busy = (state_q == StClear);
  assign hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy;

  always_comb begin
    pred_target = lk_pc4;
    if (hit) begin
      pred_target = {lk_pc4[31:28], imm_q[lk_idx], 2'b00};
    end
  end

  // Update path: the target must share the region of upd_pc + 4 so it can be rebuilt on lookup
  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[31:IDX_W+2];
  assign up_pc4     = upd_pc + 32'd4;
  assign upd_legal  = (upd_target[1:0] == 2'b00) && (upd_target[31:28] == up_pc4[31:28]);
  assign upd_accept = upd_en && (state_q == StIdle) && !flush_req;
  assign upd_write  = upd_accept && upd_legal;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    upd_err_d = upd_accept && !upd_legal;
    case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (upd_write) begin
          valid_d[up_idx] = 1'b1;
        end
      end
      StClear: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      valid_q   <= '0;
      upd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      upd_err_q <= upd_err_d;
    end
  end

  // Tag and payload need no reset: they are qualified by the valid bits
  always_ff @(posedge CLK) begin
    if (upd_write) begin
      tag_q[up_idx] <= up_tag;
      imm_q[up_idx] <= upd_target[27:2];
    end
  end

  assign upd_err = upd_err_q;

`ifdef JTB_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_en) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_lookup_en;
  assign unused_lookup_en = lookup_en;
`endif

endmodule

// File: tb/tb_jump_target_buffer.sv
// Directed self-checking bench for jump_target_buffer (DEPTH=16); stats checks when JTB_STATS_EN.
module tb_jump_target_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        hit;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_err;
  logic        flush_req;
  logic        busy;
`ifdef JTB_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  jump_target_buffer #(.DEPTH(16)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .lookup_en   (lookup_en),
    .lookup_pc   (lookup_pc),
    .hit         (hit),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_err     (upd_err),
    .flush_req   (flush_req),
    .busy        (busy)
`ifdef JTB_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  typedef struct {
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [31:0] lookup_pc;
    logic        exp_hit;
    logic [31:0] exp_pred;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    upd_en    = 1'b0;
    flush_req = 1'b0;
    lookup_en = 1'b0;
  endtask

  task automatic write_entry(input logic [31:0] pc, input logic [31:0] tgt);
    @(negedge CLK);
    upd_en     = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    @(negedge CLK);
    upd_en     = 1'b0;
  endtask

  initial begin
    int n;
    // Each vector is one cycle: lookup/err reflect state before that cycle's rising edge.
    vecs[0]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 32'h0000_0044, 1'b0};
    vecs[1]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 32'h0040_0010, 1'b0, 32'h0040_0014, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         32'h0,         32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,         32'h0,         32'h0040_0050, 1'b0, 32'h0040_0054, 1'b0};
    vecs[4]  = '{1'b1, 32'h0FFF_FFFC, 32'h1000_0000, 32'h0FFF_FFFC, 1'b0, 32'h1000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0,         32'h0FFF_FFFC, 1'b1, 32'h1000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'h2000_0000, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         32'h0,         32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0010, 1'b0, 32'h0000_0014, 1'b0};
    vecs[9]  = '{1'b1, 32'h0040_0020, 32'h0040_0102, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         32'h0,         32'h0040_0020, 1'b0, 32'h0040_0024, 1'b1};

    nRST       = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    lookup_pc  = 32'h0000_0040;
    idle_inputs();
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_err", {31'b0, upd_err}, 32'd0);
    chk("reset_hit", {31'b0, hit}, 32'd0);
    chk("reset_pred", pred_target, 32'h0000_0044);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      upd_en     = vecs[i].upd_en;
      upd_pc     = vecs[i].upd_pc;
      upd_target = vecs[i].upd_target;
      lookup_pc  = vecs[i].lookup_pc;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_pred", i), pred_target, vecs[i].exp_pred);
      chk($sformatf("vec%0d_err", i), {31'b0, upd_err}, {31'b0, vecs[i].exp_err});
    end
    @(negedge CLK);
    upd_en = 1'b0;

    // Fill all 16 entries.
    for (int i = 0; i < 16; i++) write_entry(32'h1000 + 32'(4 * i), 32'h2000 + 32'(16 * i));
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("fill%0d_hit", i), {31'b0, hit}, 32'd1);
      chk($sformatf("fill%0d_pred", i), pred_target, 32'h2000 + 32'(16 * i));
      @(negedge CLK);
    end

    // Flush with a simultaneous update: flush wins, lookups normal in the request cycle.
    flush_req  = 1'b1;
    upd_en     = 1'b1;
    upd_pc     = 32'h1000;
    upd_target = 32'h3000;
    lookup_pc  = 32'h1000;
    #1;
    chk("flushcyc_busy", {31'b0, busy}, 32'd0);
    chk("flushcyc_hit", {31'b0, hit}, 32'd1);
    @(negedge CLK);
    flush_req = 1'b0;
    n = 0;
    for (int k = 0; k < 24; k++) begin
      lookup_pc  = 32'h1000 + 32'(4 * (k % 16));
      upd_pc     = 32'h1000 + 32'(4 * (k % 16));
      upd_target = 32'h3000;
      upd_en     = 1'b1;
      flush_req  = (k == 5);
      #1;
      if (!busy) break;
      n++;
      chk($sformatf("sweep%0d_hit", k), {31'b0, hit}, 32'd0);
      chk($sformatf("sweep%0d_err", k), {31'b0, upd_err}, 32'd0);
      @(negedge CLK);
    end
    upd_en    = 1'b0;
    flush_req = 1'b0;
    chk("sweep_len", 32'(n), 32'd16);
    chk("post_sweep_err", {31'b0, upd_err}, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("postflush%0d_hit", i), {31'b0, hit}, 32'd0);
      @(negedge CLK);
    end

    // Reset during sweep cycle 7 aborts immediately.
    write_entry(32'h1038, 32'h4000);
    lookup_pc = 32'h1038;
    #1;
    chk("pre_rst_hit", {31'b0, hit}, 32'd1);
    @(negedge CLK);
    flush_req = 1'b1;
    @(negedge CLK);
    flush_req = 1'b0;
    repeat (6) @(negedge CLK);
    #1;
    chk("sweep7_busy", {31'b0, busy}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hit", {31'b0, hit}, 32'd0);
    chk("midrst_pred", pred_target, 32'h0000_103C);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    chk("postrst_hit", {31'b0, hit}, 32'd0);
    chk("postrst_busy", {31'b0, busy}, 32'd0);

`ifdef JTB_STATS_EN
    chk("stats_rst_hit", hit_cnt, 32'd0);
    chk("stats_rst_miss", miss_cnt, 32'd0);
    write_entry(32'h1000, 32'h2000);
    lookup_en = 1'b1;
    lookup_pc = 32'h1000;
    repeat (3) @(negedge CLK);
    lookup_pc = 32'h5000;
    repeat (2) @(negedge CLK);
    lookup_en = 1'b0;
    lookup_pc = 32'h1000;
    @(negedge CLK);
    lookup_pc = 32'h5000;
    @(negedge CLK);
    #1;
    chk("stats_hit", hit_cnt, 32'd3);
    chk("stats_miss", miss_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
